furv_dmem: RTL and testbench
============================

Name: furv_dmem

Overview:
- Data-memory responder for the furv core's data port. It is the slave end of the core's mem / mem_read / addr / data interface.
- Services loads and stores to a word-addressed on-chip RAM.
- Exposes a console MMIO byte port at 0x400 that drains through a small FIFO to a valid/ready byte stream.
- Replaces ad-hoc bench sniffing of stores to 1024 with a real peripheral that core benches and top-level both instantiate.

Parameters:
- RAM_WORDS, 256, RAM depth in 32-bit words; decodes byte addresses 0 .. 4*RAM_WORDS-1 (must be a power of 2, 4*RAM_WORDS <= MMIO_BASE).
- MMIO_BASE, 32'h0000_0400, console TX data register; MMIO_BASE+4 is the status register.
- FIFO_DEPTH, 4, console FIFO entries (power of 2, >= 2).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem  in  1  core requests a data access this cycle; held until ready
- mem_read  in  1  1 = load, 0 = store; held with mem
- addr  in  32  byte address; held with mem
- data  in  32  store data from core, right-aligned (byte in [7:0], half in [15:0])
- size  in  2  store width: 00 byte, 01 half, 10 word, 11 reserved
- rdata  out  32  load result: aligned word containing addr
- ready  out  1  access completes at this rising edge
- tx_valid  out  1  console byte available
- tx_data  out  8  console byte
- tx_ready  in  1  sink accepts tx_data when tx_valid && tx_ready

Behaviour:
- Reset (async assert, sync release): state IDLE, rdata=0, FIFO empty, tx_valid=0. ready is 0 while in reset. RAM contents are not reset.
- FSM states:
  - IDLE: ready is combinational from the current request.
  - LOAD_RESP: ready=1, rdata valid.
- Store, RAM region (addr < 4*RAM_WORDS):
  - ready=1 in the same cycle; byte lanes are written at that edge.
  - Lane enables by size:
    - byte: lane addr[1:0].
    - half: lanes {addr[1],0} and {addr[1],1}; requires addr[0]=0.
    - word: all four lanes; requires addr[1:0]=0.
  - Store data is replicated into the selected lanes.
  - Misaligned access or size=11: no write, ready=1 (the access is dropped).
- Store, MMIO_BASE:
  - Pushes data[7:0] into the FIFO.
  - ready=1 if FIFO not full, or full && tx_ready (pop and push in the same edge, occupancy unchanged).
  - Otherwise ready=0 and the core stalls; the request must remain stable.
- Store to MMIO_BASE+4 or any unmapped address: ready=1, no effect.
- Load, any address:
  - In IDLE, mem && mem_read: ready=0 and go to LOAD_RESP.
  - In LOAD_RESP: ready=1, rdata holds the registered result; return to IDLE at that edge.
  - Latency is exactly one wait state. Back-to-back loads alternate IDLE/LOAD_RESP.
- Load data:
  - RAM: RAM[addr[log2(RAM_WORDS)+1:2]].
  - MMIO_BASE+4: {30'b0, fifo_full, fifo_empty}.
  - MMIO_BASE and unmapped: 32'h0.
- rdata holds its last value outside LOAD_RESP.
- FIFO:
  - tx_valid = !empty; tx_data = head entry.
  - Pop on tx_valid && tx_ready.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full/empty are derived from MSB compare.
  - Push while empty: the byte is visible on tx_data the next cycle (no fall-through).
- mem deasserted: ready=0, no state change.
- Reset mid-load: the pending response is discarded. The core is reset alongside and does not retry.

Decomposition:
- furv_dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - MMIO offsets REG_TX=0, REG_STATUS=4.
  - FSM state typedef {IDLE, LOAD_RESP}.
  - function lane_mask(size, addr[1:0]) returning 4-bit enables (0 on misalign).
- One sub-module, furv_byte_fifo: parameterised synchronous FIFO with push/pop/full/empty/head. Reset uses the same rst_n.

Test Plan:
- Store word 32'hDEADBEEF to 0x10, then load 0x10 -> ready low one cycle, then ready=1 with rdata=32'hDEADBEEF; load 0x10 again -> same value, one wait state each.
- After the word store, sb 0xAA to 0x12 then sh 0x1234 to 0x10; load 0x10 -> 32'hDEAA1234. sh to 0x11 -> no change, ready=1.
- Run the core's counting loop (sb 0..15 to 0x400) with tx_ready=1 -> tx stream carries bytes 0x00..0x0F in order, no gaps beyond FIFO latency, no core stall.
- tx_ready=0, five stores to 0x400 -> first four accepted; fifth holds ready=0; status load reads 32'h2. Raise tx_ready -> fifth accepted in the same cycle as the pop, bytes drain in order.
- Load from 0x800 (unmapped) -> rdata=0 after one wait state; store to 0x800 -> ready=1, a later RAM readback is unchanged.
- Assert rst_n low in the LOAD_RESP cycle -> ready=0, tx_valid=0, rdata=0 immediately (async). After release, the FSM is in IDLE and the status load reads 32'h1.

Source files
------------

// File: rtl/furv_dmem_pkg.sv
// Shared definitions for the furv data-memory responder: store size codes,
// console MMIO register offsets, FSM state type and the byte-lane decoder.
package furv_dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] REG_TX     = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS = 32'h0000_0004;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_RESP = 1'b1
    } dmem_state_e;

    // Byte-lane write enables for a store; all zero for a misaligned
    // access or the reserved size code, which drops the store.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] a);
        logic [3:0] m;
        m = '0;
        case (size)
            SZ_BYTE: m = 4'b0001 << a;
            SZ_HALF: if (!a[0]) m = a[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: if (a == 2'b00) m = 4'b1111;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/furv_dmem_fifo.sv
// Small synchronous byte FIFO feeding the console stream. Pointers carry one
// extra wrap bit so full and empty are told apart by the MSB compare. The
// head is read from storage, so a byte pushed into an empty FIFO appears on
// head_o the following cycle.
module furv_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    logic        do_push, do_pop;

    // Status flags, head entry and pointer advance.
    always_comb begin
        empty_o = (wr_q == rd_q);
        full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        head_o  = mem_q[rd_q[AW-1:0]];
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        wr_d    = wr_q + {{AW{1'b0}}, do_push};
        rd_d    = rd_q + {{AW{1'b0}}, do_pop};
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Entry storage; not reset, only read behind a valid pointer.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/furv_dmem.sv
// Data-memory responder for the furv core data port: word-addressed RAM with
// byte-lane stores, one-wait-state loads, and a console TX byte register whose
// writes drain through a FIFO onto a valid/ready byte stream.
module furv_dmem
    import furv_dmem_pkg::*;
#(
    parameter int unsigned RAM_WORDS  = 256,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_0400,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int unsigned IDX_W     = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

    dmem_state_e state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] ram_q [RAM_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic             in_ram, is_tx, is_status;
    logic [3:0]       lane_we;
    logic [31:0]      wdata, load_val;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]       fifo_head;
    logic             ready_c;

    // Address decode and store data replicated across the selected lanes.
    always_comb begin
        word_idx  = addr[IDX_W+1:2];
        in_ram    = (addr < RAM_BYTES);
        is_tx     = (addr == MMIO_BASE + REG_TX);
        is_status = (addr == MMIO_BASE + REG_STATUS);
        case (size)
            SZ_BYTE: wdata = {4{data[7:0]}};
            SZ_HALF: wdata = {2{data[15:0]}};
            default: wdata = data;
        endcase
    end

    // Value captured into rdata when a load enters its wait state.
    always_comb begin
        load_val = '0;
        if (in_ram)         load_val = ram_q[word_idx];
        else if (is_status) load_val = {30'b0, fifo_full, fifo_empty};
    end

    // Next-state, handshake and write-strobe logic. Everything is gated by
    // rst_n so ready stays low and nothing is written while reset is held.
    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        ready_c   = 1'b0;
        lane_we   = '0;
        fifo_push = 1'b0;
        if (rst_n) begin
            case (state_q)
                LOAD_RESP: begin
                    ready_c = 1'b1;
                    state_d = IDLE;
                end
                IDLE: begin
                    if (mem) begin
                        if (mem_read) begin
                            state_d = LOAD_RESP;
                            rdata_d = load_val;
                        end else if (is_tx) begin
                            // A full FIFO still accepts when the sink pops at
                            // the same edge.
                            ready_c   = !fifo_full || tx_ready;
                            fifo_push = ready_c;
                        end else begin
                            ready_c = 1'b1;
                            if (in_ram) lane_we = lane_mask(size, addr[1:0]);
                        end
                    end
                end
            endcase
        end
    end

    // FSM state and registered load data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM byte-lane writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (lane_we[i]) ram_q[word_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    // Console sink handshake.
    always_comb begin
        tx_valid = !fifo_empty;
        tx_data  = fifo_head;
        fifo_pop = tx_valid && tx_ready;
        ready    = ready_c;
        rdata    = rdata_q;
    end

    furv_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (fifo_push),
        .din_i  (data[7:0]),
        .pop_i  (fifo_pop),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .head_o (fifo_head)
    );

endmodule

// File: tb/tb_furv_dmem.sv
// Randomised scoreboard bench for furv_dmem: a byte-level memory model and a
// console occupancy/queue model predict every ready, tx and load response.
module tb_furv_dmem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem = 1'b0;
    logic        mem_read = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] data = '0;
    logic [1:0]  size = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic        tx_valid;
    logic [7:0]  tx_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  ram_m [1024];
    int          occ_m = 0;
    logic [7:0]  tx_q [$];
    logic [31:0] exp_q [$];
    bit          ld_wait = 1'b0;
    bit          rand_tx = 1'b0;

    always #5 clk = ~clk;

    furv_dmem #(
        .RAM_WORDS (256),
        .MMIO_BASE (32'h0000_0400),
        .FIFO_DEPTH(4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem     (mem),
        .mem_read(mem_read),
        .addr    (addr),
        .data    (data),
        .size    (size),
        .rdata   (rdata),
        .ready   (ready),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a);
        logic [31:0] b;
        if (a < 32'd1024) begin
            b = a & 32'hFFFF_FFFC;
            return {ram_m[b+3], ram_m[b+2], ram_m[b+1], ram_m[b]};
        end
        if (a == 32'h404) return {30'b0, occ_m == 4, occ_m == 0};
        return 32'h0;
    endfunction

    function automatic int store_len(input logic [1:0] sz, input logic [31:0] a);
        int n;
        case (sz)
            2'b00:   n = 1;
            2'b01:   n = 2;
            2'b10:   n = 4;
            default: n = 0;
        endcase
        if (n != 0 && (a % n) != 0) n = 0;
        return n;
    endfunction

    // Reference model, advanced at every clock edge from the driven request.
    always @(posedge clk or negedge rst_n) begin
        bit pop;
        bit push;
        int n;
        if (!rst_n) begin
            occ_m   = 0;
            tx_q.delete();
            exp_q.delete();
            ld_wait = 1'b0;
        end else begin
            pop  = (occ_m > 0) && tx_ready;
            push = 1'b0;
            if (ld_wait) begin
                ld_wait = 1'b0;
            end else if (mem && mem_read) begin
                exp_q.push_back(model_load(addr));
                ld_wait = 1'b1;
            end else if (mem) begin
                if (addr == 32'h400) begin
                    push = (occ_m < 4) || tx_ready;
                end else if (addr < 32'd1024) begin
                    n = store_len(size, addr);
                    for (int k = 0; k < n; k++) ram_m[addr+k] = data[8*k +: 8];
                end
            end
            if (pop) begin
                occ_m--;
                void'(tx_q.pop_front());
            end
            if (push) begin
                occ_m++;
                tx_q.push_back(data[7:0]);
            end
        end
    end

    // Monitor: compares handshake, console stream and load data each cycle.
    always @(negedge clk) begin
        logic exp_rdy;
        if (!rst_n)                exp_rdy = 1'b0;
        else if (ld_wait)          exp_rdy = 1'b1;
        else if (!mem || mem_read) exp_rdy = 1'b0;
        else if (addr == 32'h400)  exp_rdy = (occ_m < 4) || tx_ready;
        else                       exp_rdy = 1'b1;
        check("ready", 32'(ready), 32'(exp_rdy));
        check("tx_valid", 32'(tx_valid), 32'(occ_m > 0));
        if (tx_valid && tx_ready && tx_q.size() > 0) check("tx_data", 32'(tx_data), 32'(tx_q[0]));
        if (rst_n && ld_wait && ready) begin
            if (exp_q.size() == 0) check("rdata_unexpected", 32'(ready), 32'h0);
            else check("rdata", rdata, exp_q.pop_front());
        end
    end

    // Random sink back-pressure.
    always @(posedge clk) begin
        if (rand_tx) begin
            #1;
            tx_ready = 1'($urandom_range(0, 1));
        end
    end

    // Present one request (called just after a rising edge) and hold it until ready.
    task automatic access(input logic rd, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] sz, output logic [31:0] got, output int waits);
        bit done;
        done = 1'b0;
        got = '0;
        waits = 0;
        mem = 1'b1;
        mem_read = rd;
        addr = a;
        data = d;
        size = sz;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (ready) begin
                done = 1'b1;
                got = rdata;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: addr %h never ready", a);
        end
    endtask

    task automatic idle(input int n);
        mem = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        int w;

        repeat (2) @(posedge clk);
        mem = 1'b1;
        @(negedge clk);
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        check("reset_tx_valid", 32'(tx_valid), 32'h0);
        mem = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 256; i++) access(1'b0, 32'(i * 4), $urandom, 2'b10, got, w);

        access(1'b0, 32'h10, 32'hDEADBEEF, 2'b10, got, w);
        check("sw_wait", 32'(w), 32'h0);
        access(1'b1, 32'h10, 32'h0, 2'b00, got, w);
        check("lw_first", got, 32'hDEADBEEF);
        check("lw_first_wait", 32'(w), 32'h1);
        access(1'b1, 32'h10, 32'h0, 2'b00, got, w);
        check("lw_again", got, 32'hDEADBEEF);
        check("lw_again_wait", 32'(w), 32'h1);

        access(1'b0, 32'h12, 32'h0000_00AA, 2'b00, got, w);
        access(1'b0, 32'h10, 32'h0000_1234, 2'b01, got, w);
        access(1'b1, 32'h10, 32'h0, 2'b00, got, w);
        check("lw_merge", got, 32'hDEAA1234);
        access(1'b0, 32'h11, 32'h0000_FFFF, 2'b01, got, w);
        check("sh_misalign_wait", 32'(w), 32'h0);
        access(1'b1, 32'h10, 32'h0, 2'b00, got, w);
        check("lw_after_misalign", got, 32'hDEAA1234);

        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            access(1'b0, 32'h400, 32'(i), 2'b00, got, w);
            check("count_no_stall", 32'(w), 32'h0);
        end
        idle(4);
        check("count_drained", 32'(tx_valid), 32'h0);

        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 32'h400, 32'hA0 + 32'(i), 2'b00, got, w);
            check("fill_no_stall", 32'(w), 32'h0);
        end
        access(1'b1, 32'h404, 32'h0, 2'b00, got, w);
        check("status_full", got, 32'h2);
        mem = 1'b1;
        mem_read = 1'b0;
        addr = 32'h400;
        data = 32'hA4;
        size = 2'b00;
        repeat (3) begin
            @(negedge clk);
            check("fifth_stall", 32'(ready), 32'h0);
            @(posedge clk);
            #1;
        end
        tx_ready = 1'b1;
        @(negedge clk);
        check("fifth_accept", 32'(ready), 32'h1);
        @(posedge clk);
        #1;
        idle(8);
        check("overflow_drained", 32'(tx_valid), 32'h0);

        access(1'b1, 32'h800, 32'h0, 2'b00, got, w);
        check("unmapped_load", got, 32'h0);
        check("unmapped_load_wait", 32'(w), 32'h1);
        access(1'b0, 32'h800, 32'h1111_1111, 2'b10, got, w);
        check("unmapped_store_wait", 32'(w), 32'h0);
        access(1'b0, 32'h404, 32'h2222_2222, 2'b10, got, w);
        access(1'b1, 32'h10, 32'h0, 2'b00, got, w);
        check("ram_untouched", got, 32'hDEAA1234);

        rand_tx = 1'b1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0, 1: access(1'b0, 32'($urandom_range(0, 1023)), $urandom,
                             2'($urandom_range(0, 3)), got, w);
                2, 3: access(1'b1, 32'($urandom_range(0, 1023)), 32'h0, 2'b00, got, w);
                4:    access(1'b0, 32'h400, $urandom, 2'b00, got, w);
                5:    access(1'b1, 32'h404, 32'h0, 2'b00, got, w);
                6: begin
                    case ($urandom_range(0, 3))
                        0:       a = 32'h401;
                        1:       a = 32'h404;
                        2:       a = 32'h800;
                        default: a = 32'hFFFF_FFFC;
                    endcase
                    access(1'($urandom_range(0, 1)), a, $urandom, 2'b10, got, w);
                end
                default: idle($urandom_range(0, 2));
            endcase
        end
        rand_tx = 1'b0;
        @(posedge clk);
        #2;
        tx_ready = 1'b1;
        idle(8);

        tx_ready = 1'b0;
        access(1'b0, 32'h400, 32'h77, 2'b00, got, w);
        mem = 1'b1;
        mem_read = 1'b1;
        addr = 32'h10;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        mem = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(1'b1, 32'h404, 32'h0, 2'b00, got, w);
        check("status_after_reset", got, 32'h1);
        check("status_after_reset_wait", 32'(w), 32'h1);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
